// File: rtl/instr_fetch_seq_if.sv
// ---------------------------------------------------------------------------
// instr_fetch_seq_if
// Instruction-memory read channel between the fetch sequencer and the
// instruction memory.
//   imem_req   : read request, held high until imem_ack
//   imem_addr  : word address, stable while imem_req is high
//   imem_rdata : read data, valid in the imem_ack cycle
//   imem_ack   : read complete
// master = fetch sequencer side, slave = memory side.
// ---------------------------------------------------------------------------
interface instr_fetch_seq_if #(
    parameter int ADDR_W = 16
);
    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_rdata;
    logic              imem_ack;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_rdata,
        input  imem_ack
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_rdata,
        output imem_ack
    );
endinterface

// File: rtl/instr_fetch_seq.sv
// ---------------------------------------------------------------------------
// instr_fetch_seq
// Instruction fetch/sequencing stage feeding the execute datapath. Fetches
// one- or two-word instructions over the imem req/ack channel, holds them in
// instr0/instr1 for the whole EXEC phase, owns the PC and applies jumps
// requested by execute. Stops in HALT on the end opcode.
//
// Ports:
//   clk           : system clock, rising edge
//   reset_n       : asynchronous active-low reset
//   start         : 1-cycle pulse, leaves HALT and fetches from RESET_PC
//   imem          : instruction-memory read channel (master modport)
//   exec_stall    : execute needs more cycles, hold EXEC
//   jump_en       : taken jump, sampled in the final EXEC cycle
//   jump_addr     : jump target
//   instr0        : first instruction word (opcode in [31:24])
//   instr1        : second word of two-word ops, else 0
//   current_state : shared STATE_* encoding to the datapath
//   pc            : address of the next word to fetch
//   halted        : high in HALT
// ---------------------------------------------------------------------------
module instr_fetch_seq #(
    parameter int                ADDR_W   = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     start,
    instr_fetch_seq_if.master        imem,
    input  logic                     exec_stall,
    input  logic                     jump_en,
    input  logic [ADDR_W-1:0]        jump_addr,
    output logic [31:0]              instr0,
    output logic [31:0]              instr1,
    output logic [3:0]               current_state,
    output logic [ADDR_W-1:0]        pc,
    output logic                     halted
);
    // Shared state encoding seen by the datapath
    localparam logic [3:0] STATE_HLT    = 4'h0;
    localparam logic [3:0] STATE_FETCH0 = 4'h1;
    localparam logic [3:0] STATE_FETCH1 = 4'h2;
    localparam logic [3:0] STATE_EXEC   = 4'h3;

    // Opcodes the sequencer has to recognise
    localparam logic [7:0] OP_LIMM32 = 8'h02;
    localparam logic [7:0] OP_LBSET  = 8'h03;
    localparam logic [7:0] OP_END    = 8'hFF;

    localparam logic [ADDR_W-1:0] PC_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    typedef enum logic [3:0] {
        ST_HALT   = STATE_HLT,
        ST_FETCH0 = STATE_FETCH0,
        ST_FETCH1 = STATE_FETCH1,
        ST_EXEC   = STATE_EXEC
    } state_t;

    state_t            r_state;
    state_t            w_next_state;
    logic [ADDR_W-1:0] r_pc;
    logic [31:0]       r_instr0;
    logic [31:0]       r_instr1;

    logic              w_fetching;
    logic              w_ack;
    logic              w_two_word;
    logic              w_is_end;
    logic [ADDR_W-1:0] w_pc_inc;

    assign w_fetching = (r_state == ST_FETCH0) || (r_state == ST_FETCH1);
    // An ack outside a fetch state is a stray and must not move anything
    assign w_ack      = w_fetching && imem.imem_ack;
    assign w_two_word = (imem.imem_rdata[31:24] == OP_LIMM32) ||
                        (imem.imem_rdata[31:24] == OP_LBSET);
    assign w_is_end   = (r_instr0[31:24] == OP_END);
    // Natural wrap at 2^ADDR_W, also between the two words of one instruction
    assign w_pc_inc   = r_pc + PC_ONE;

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_HALT;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_HALT: begin
                if (start) w_next_state = ST_FETCH0;
            end
            ST_FETCH0: begin
                if (w_ack) w_next_state = w_two_word ? ST_FETCH1 : ST_EXEC;
            end
            ST_FETCH1: begin
                if (w_ack) w_next_state = ST_EXEC;
            end
            ST_EXEC: begin
                // The exit cycle is the first one without a stall
                if (!exec_stall) w_next_state = w_is_end ? ST_HALT : ST_FETCH0;
            end
            default: w_next_state = ST_HALT;
        endcase
    end

    // PC and instruction registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pc     <= RESET_PC;
            r_instr0 <= '0;
            r_instr1 <= '0;
        end else begin
            case (r_state)
                ST_HALT: begin
                    if (start) r_pc <= RESET_PC;
                end
                ST_FETCH0: begin
                    if (w_ack) begin
                        r_instr0 <= imem.imem_rdata;
                        r_pc     <= w_pc_inc;
                        if (!w_two_word) r_instr1 <= '0;
                    end
                end
                ST_FETCH1: begin
                    if (w_ack) begin
                        r_instr1 <= imem.imem_rdata;
                        r_pc     <= w_pc_inc;
                    end
                end
                ST_EXEC: begin
                    // End opcode keeps the PC and ignores any jump request
                    if (!exec_stall && !w_is_end && jump_en) r_pc <= jump_addr;
                end
                default: ;
            endcase
        end
    end

    // Request is a pure function of state so it stays up, with the fresh
    // address, across the FETCH0 -> FETCH1 transition
    assign imem.imem_req  = w_fetching;
    assign imem.imem_addr = w_fetching ? r_pc : '0;

    assign instr0        = r_instr0;
    assign instr1        = r_instr1;
    assign current_state = r_state;
    assign pc            = r_pc;
    assign halted        = (r_state == ST_HALT);
endmodule
